// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared types and defaults for the memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int DEFAULT_MEM_BYTES = 2048;

endpackage
`default_nettype wire

// File: rtl/byte_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_unit
// Description : Big-endian lane extract/extend for loads and lane merge for
//               sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // Offset 0 is the most significant byte of the word.
        w_byte = 8'h00;
        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase
        w_half = i_offset[1] ? i_word[15:0] : i_word[31:16];

        o_load_data = 32'h0000_0000;
        case (i_size)
            SZ_BYTE: o_load_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_load_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            SZ_WORD: o_load_data = i_word;
            default: o_load_data = 32'h0000_0000;
        endcase

        o_merged = i_word;
        case (i_size)
            SZ_BYTE: begin
                case (i_offset)
                    2'd0:    o_merged[31:24] = i_wdata[7:0];
                    2'd1:    o_merged[23:16] = i_wdata[7:0];
                    2'd2:    o_merged[15:8]  = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                if (i_offset[1]) o_merged[15:0]  = i_wdata[15:0];
                else             o_merged[31:16] = i_wdata[15:0];
            end
            SZ_WORD: o_merged = i_wdata;
            default: o_merged = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Byte/half/word load-store front end for a 32-bit big-endian
//               word memory, with read-modify-write for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_BYTES = DEFAULT_MEM_BYTES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    localparam logic [31:0] c_max_base = 32'(MEM_BYTES - 4);

    state_e      r_state_q,      w_state_d;
    logic [31:0] r_mem_adr_q,    w_mem_adr_d;
    logic [31:0] r_mem_wd_q,     w_mem_wd_d;
    logic        r_mem_we_q,     w_mem_we_d;
    logic        r_resp_valid_q, w_resp_valid_d;
    logic [31:0] r_resp_rdata_q, w_resp_rdata_d;
    logic        r_resp_err_q,   w_resp_err_d;
    logic        r_write_q,      w_write_d;
    logic [1:0]  r_size_q,       w_size_d;
    logic [1:0]  r_offset_q,     w_offset_d;
    logic        r_unsigned_q,   w_unsigned_d;
    logic [31:0] r_wdata_q,      w_wdata_d;

    logic [31:0] w_word_base;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_word_base = {req_addr[31:2], 2'b00};

    always_comb begin
        w_fault = (req_size == SZ_RSVD)
               || ((req_size == SZ_HALF) && req_addr[0])
               || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
               || (w_word_base > c_max_base);
    end

    byte_lane_unit u_lanes (
        .i_word      (mem_rd),
        .i_offset    (r_offset_q),
        .i_size      (r_size_q),
        .i_unsigned  (r_unsigned_q),
        .i_wdata     (r_wdata_q),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_mem_adr_d    = r_mem_adr_q;
        w_mem_wd_d     = r_mem_wd_q;
        w_mem_we_d     = 1'b0;
        w_resp_valid_d = 1'b0;
        w_resp_rdata_d = r_resp_rdata_q;
        w_resp_err_d   = r_resp_err_q;
        w_write_d      = r_write_q;
        w_size_d       = r_size_q;
        w_offset_d     = r_offset_q;
        w_unsigned_d   = r_unsigned_q;
        w_wdata_d      = r_wdata_q;

        case (r_state_q)
            IDLE: begin
                if (req_valid) begin
                    w_mem_adr_d    = w_word_base;
                    w_write_d      = req_write;
                    w_size_d       = req_size;
                    w_offset_d     = req_addr[1:0];
                    w_unsigned_d   = req_unsigned;
                    w_wdata_d      = req_wdata;
                    w_resp_rdata_d = 32'h0000_0000;
                    w_resp_err_d   = w_fault;
                    if (w_fault) begin
                        w_state_d      = RESP;
                        w_resp_valid_d = 1'b1;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        // Full-word stores need no read, write straight away.
                        w_mem_wd_d = req_wdata;
                        w_mem_we_d = 1'b1;
                        w_state_d  = WRITE;
                    end else begin
                        w_state_d = READ;
                    end
                end
            end
            READ: begin
                if (r_write_q) begin
                    w_mem_wd_d = w_merged;
                    w_mem_we_d = 1'b1;
                    w_state_d  = WRITE;
                end else begin
                    w_resp_rdata_d = w_load_data;
                    w_resp_valid_d = 1'b1;
                    w_state_d      = RESP;
                end
            end
            WRITE: begin
                w_resp_valid_d = 1'b1;
                w_state_d      = RESP;
            end
            RESP: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q      <= IDLE;
            r_mem_adr_q    <= 32'h0000_0000;
            r_mem_wd_q     <= 32'h0000_0000;
            r_mem_we_q     <= 1'b0;
            r_resp_valid_q <= 1'b0;
            r_resp_rdata_q <= 32'h0000_0000;
            r_resp_err_q   <= 1'b0;
            r_write_q      <= 1'b0;
            r_size_q       <= 2'b00;
            r_offset_q     <= 2'b00;
            r_unsigned_q   <= 1'b0;
            r_wdata_q      <= 32'h0000_0000;
        end else begin
            r_state_q      <= w_state_d;
            r_mem_adr_q    <= w_mem_adr_d;
            r_mem_wd_q     <= w_mem_wd_d;
            r_mem_we_q     <= w_mem_we_d;
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_rdata_q <= w_resp_rdata_d;
            r_resp_err_q   <= w_resp_err_d;
            r_write_q      <= w_write_d;
            r_size_q       <= w_size_d;
            r_offset_q     <= w_offset_d;
            r_unsigned_q   <= w_unsigned_d;
            r_wdata_q      <= w_wdata_d;
        end
    end

    assign req_ready  = (r_state_q == IDLE);
    assign resp_valid = r_resp_valid_q;
    assign resp_rdata = r_resp_rdata_q;
    assign resp_err   = r_resp_err_q;
    assign mem_adr    = r_mem_adr_q;
    assign mem_wd     = r_mem_wd_q;
    assign mem_we     = r_mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a byte-array memory
//               and a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int MEM_BYTES = 2048;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err, mem_we;
    logic [31:0] resp_rdata, mem_adr, mem_wd, mem_rd;

    mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_adr      (mem_adr),
        .mem_wd       (mem_wd),
        .mem_we       (mem_we),
        .mem_rd       (mem_rd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 5));
    endfunction

    // Big-endian word memory: combinational read, whole-word write.
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic        mem_init;
    logic [10:0] rd_base;
    assign rd_base = {mem_adr[10:2], 2'b00};
    assign mem_rd  = {mem[rd_base], mem[rd_base + 11'd1], mem[rd_base + 11'd2], mem[rd_base + 11'd3]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= init_byte(i);
        end else if (mem_we) begin
            mem[rd_base]         <= mem_wd[31:24];
            mem[rd_base + 11'd1] <= mem_wd[23:16];
            mem[rd_base + 11'd2] <= mem_wd[15:8];
            mem[rd_base + 11'd3] <= mem_wd[7:0];
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          wes;
        logic [31:0] wadr;
        logic [31:0] wd;
        int          acc;
    } exp_t;

    logic [7:0] ref_mem [0:MEM_BYTES-1];
    exp_t       sbq[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         we_cnt = 0;
    logic       in_rst_test = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got timeout/unexpected event, expected none", name);
    endtask

    // Reference: treats memory as a flat byte array, addr is the MSB of the access.
    function automatic exp_t model(input logic w, input logic [1:0] sz, input logic u,
                                   input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n, ai, b;
        logic [31:0] v;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e.rdata = 32'h0;
        e.err   = 1'b0;
        e.wes   = 0;
        e.wd    = 32'h0;
        e.acc   = 0;
        e.wadr  = {a[31:2], 2'b00};
        if (sz == 2'd3 || (int'(a[1:0]) % n) != 0 || e.wadr > 32'(MEM_BYTES - 4)) begin
            e.err = 1'b1;
            e.lat = 1;
            return e;
        end
        ai = int'(a[10:0]);
        if (!w) begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[ai + i]);
            if (n < 4 && !u && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
            e.rdata = v;
            e.lat   = 2;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[ai + i] = 8'(wd >> (8 * (n - 1 - i)));
            b     = ai & ~3;
            e.wd  = {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
            e.wes = 1;
            e.lat = (n == 4) ? 2 : 3;
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   n;
        req_valid = 1'b1; req_write = w; req_size = sz;
        req_unsigned = u; req_addr = a; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            return;
        end
        e     = model(w, sz, u, a, wd);
        e.acc = cyc + 1;
        @(posedge clk);
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq.size() != 0 || !req_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || !req_ready) fail_now("drain_timeout");
    endtask

    always @(negedge clk) begin
        if (!rst && !mem_init) begin
            if (!in_rst_test) chk("req_ready", 32'(req_ready), 32'(sbq.size() == 0));
            if (mem_we) begin
                if (sbq.size() == 0) fail_now("unexpected_mem_we");
                else begin
                    we_cnt++;
                    chk("mem_adr", mem_adr, sbq[0].wadr);
                    chk("mem_wd", mem_wd, sbq[0].wd);
                end
            end
            if (resp_valid) begin
                if (sbq.size() == 0) fail_now("unexpected_resp");
                else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                    chk("mem_we_cycles", 32'(we_cnt), 32'(e.wes));
                    we_cnt = 0;
                end
            end
        end
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          r, n;

        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_adr", mem_adr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", 32'(resp_err), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        rst = 1'b0; mem_init = 1'b0;
        @(negedge clk);

        // Directed loads, sub-word stores and big-endian layout
        issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h80F0_7F01);
        issue(1'b0, 2'd0, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h20, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h20, 32'h0);
        issue(1'b0, 2'd1, 1'b1, 32'h20, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h22, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AB);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEAD_BEEF);
        issue(1'b1, 2'd1, 1'b0, 32'h32, 32'h0000_1234);
        issue(1'b0, 2'd2, 1'b0, 32'h30, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h30, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h33, 32'h0);
        // Faults and the last legal word
        issue(1'b1, 2'd1, 1'b0, 32'h21, 32'hFFFF_FFFF);
        issue(1'b0, 2'd2, 1'b0, 32'h22, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h800, 32'h0);
        issue(1'b1, 2'd3, 1'b0, 32'h20, 32'h1111_1111);
        issue(1'b1, 2'd2, 1'b0, 32'h7FC, 32'hCAFE_F00D);
        issue(1'b0, 2'd2, 1'b0, 32'h7FC, 32'h0);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);

        // Reset during the read phase of a sub-word store
        issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h0102_0304);
        wait_idle();
        in_rst_test = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0;
        req_addr = 32'h41; req_wdata = 32'h0000_0055;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_in_read", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        chk("arst_mem_we", 32'(mem_we), 32'h0);
        chk("arst_mem_adr", mem_adr, 32'h0);
        chk("arst_mem_wd", mem_wd, 32'h0);
        chk("arst_resp_valid", 32'(resp_valid), 32'h0);
        chk("arst_resp_rdata", resp_rdata, 32'h0);
        chk("arst_resp_err", 32'(resp_err), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        in_rst_test = 1'b0;
        chk("word40_after_rst", {mem[64], mem[65], mem[66], mem[67]}, 32'h0102_0304);
        issue(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);

        // Randomized back-to-back traffic
        for (int k = 0; k < 250; k++) begin
            sz = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'($urandom_range(2036, 2060));
            else if (r < 7)  a = 32'($urandom_range(0, 127));
            else             a = 32'($urandom_range(0, 2047));
            if (r >= 3) begin
                n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
                a = a & ~32'(n - 1);
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        wait_idle();

        for (int i = 0; i < MEM_BYTES; i += 4) begin
            chk($sformatf("mem_word_%0h", i),
                {mem[i], mem[i+1], mem[i+2], mem[i+3]},
                {ref_mem[i], ref_mem[i+1], ref_mem[i+2], ref_mem[i+3]});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly upstream of the unified byte-addressed instruction/data memory in the multicycle datapath. That memory has a 32-bit big-endian port: combinational read of bytes Adr..Adr+3, and a full 4-byte write on the clk edge when WE=1.
- Accepts load/store requests of byte, halfword or word size from the controller.
- Performs read-modify-write for sub-word stores, because the memory only writes whole 4-byte groups.
- Returns sign- or zero-extended load data, and flags misaligned or out-of-range accesses without touching memory.

Parameters:
MEM_BYTES, 2048, memory size in bytes; accesses whose word base exceeds MEM_BYTES-4 are faults.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=halfword, 2=word, 3=reserved (treated as fault)
req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data (0 for stores and faults)
resp_err  output  1  valid with resp_valid: misaligned, out-of-range or reserved size
mem_adr  output  32  memory address, always word base (req_addr & ~3), registered
mem_wd  output  32  memory write data, registered
mem_we  output  1  memory write enable, registered
mem_rd  input  32  memory read data (combinational from mem_adr)

Behaviour:
- Reset: state=IDLE; mem_we=0, mem_adr=0, mem_wd=0, resp_valid=0, resp_rdata=0, resp_err=0. Reset is asynchronous, so asserting rst during WRITE drops mem_we immediately and the write is lost. It is never half-done, because memory writes all 4 bytes on one edge.
- Handshake: a request is accepted on an edge with req_valid && req_ready. Request fields are captured at acceptance and need not be held. req_valid while busy is ignored. The response has no backpressure.
- Byte lanes (big-endian): off=req_addr[1:0]; byte at off occupies mem_rd[31-8*off -: 8]. Halfword at off∈{0,2} occupies [31-8*off -: 16].
- Fault check at acceptance: halfword with addr[0]≠0, word with addr[1:0]≠0, size=3, or word base > MEM_BYTES-4.
- States and transitions:
  - IDLE: on acceptance, a fault goes to RESP with err=1. A load goes to READ. A word store goes to WRITE with mem_wd=req_wdata and mem_we=1. A sub-word store goes to READ. mem_adr is loaded with the word base on every acceptance.
  - READ (one cycle): sample mem_rd.
    - Load: extract and extend into resp_rdata, then go to RESP.
    - Sub-word store: merge the store bytes into the sampled word in their lanes, other lanes unchanged. Set mem_wd=merged and mem_we=1, then go to WRITE.
  - WRITE (one cycle): mem_we=1, so memory commits at the end of this cycle; mem_we clears at that edge. Go to RESP.
  - RESP (one cycle): resp_valid=1, then go to IDLE. resp_rdata and resp_err hold until the next acceptance.
- Latency from acceptance edge to resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - fault: 1 cycle
- Throughput: one request per (latency+1) cycles; req_ready is low in READ, WRITE and RESP.
- mem_we is never asserted for loads or faulted requests.

Decomposition:
- Package mem_access_pkg holds:
  - size enum (SZ_BYTE, SZ_HALF, SZ_WORD)
  - state enum (IDLE, READ, WRITE, RESP)
  - default MEM_BYTES
- One combinational sub-module, byte_lane_unit, contains:
  - load extract/extend: inputs word, offset, size, unsigned
  - store merge: inputs old word, wdata, offset, size
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Preload 0x20=0x80F07F01. Issue lb 0x20, lbu 0x20, lh 0x20, lhu 0x20, lh 0x22. Expect 0xFFFFFF80, 0x00000080, 0xFFFF80F0, 0x000080F0, 0x00007F01. Each resp_valid appears 2 cycles after acceptance with mem_we=0 throughout.
- sb 0x21 with wdata=0x000000AB, then lw 0x20. Expect mem_we high for exactly 1 cycle with mem_wd=0x80AB7F01; resp after 3 cycles; the readback returns 0x80AB7F01.
- sw 0x30 with 0xDEADBEEF, then sh 0x32 with 0x00001234, then lw 0x30. Expect 0xDEAD1234 with big-endian byte order in memory: 0x30=DE, 0x33=34.
- Issue sh 0x21, lw 0x22, lw 0x800 (MEM_BYTES=2048), and size=3. Each gives resp_err=1 and resp_rdata=0 one cycle after acceptance; mem_we stays 0 and memory is unchanged.
- Hold req_valid continuously with back-to-back requests. Expect req_ready low in READ/WRITE/RESP, with no request lost or duplicated.
- Assert rst in the READ state of a sub-word store to 0x40 (preload 0x01020304). Expect mem_we never asserted, all outputs at reset values immediately, word 0x40 still 0x01020304, and the next request served normally.
